result_drain: RTL and testbench

RESULT_DRAIN -- requirements
Module: result_drain

---
 rtl/result_drain.sv | 154 +++++++++++++++
 tb/tb_result_drain.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// ---------------------------------------------------------------------------
// result_drain
//   Captures the LANES accumulated results of a matrix-vector multiplier job
//   on the rising edge of done_in. It then streams them one word per
//   handshake, in lane order. After the last word it pulses clr_out once so
//   the multiplier accumulators are cleared. A job-complete edge that arrives
//   while a drain is in progress is dropped and latched in the sticky overrun
//   flag.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   done_in    in   level "job complete" from the multiplier
//   c_in       in   [0:LANES-1] x DW accumulated lane results
//   out_valid  out  out_data holds a valid word
//   out_ready  in   downstream accepts the word this cycle
//   out_data   out  current result word
//   out_idx    out  lane number of out_data
//   out_last   out  high with the word for lane LANES-1
//   clr_out    out  one-cycle accumulator clear pulse
//   busy       out  drain or clear in progress
//   overrun    out  sticky: done_in rose while busy
// ---------------------------------------------------------------------------
module result_drain #(
    parameter int unsigned LANES = 8,
    parameter int unsigned DW    = 24,
    localparam int unsigned IW   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          done_in,
    input  logic [DW-1:0] c_in [0:LANES-1],
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          clr_out,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          done_q;
    logic          overrun_q, overrun_d;
    logic [DW-1:0] hold_q [0:LANES-1];
    logic          rise;
    logic          capture;
    logic          at_last;

    assign rise    = done_in & ~done_q;
    assign at_last = (idx_q == IW'(LANES - 1));

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        capture   = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (at_last) begin
                        state_d = CLEAR;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            CLEAR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A rise in any non-IDLE state, including the final CLEAR cycle,
        // is never captured and only marks the overrun.
        if (rise && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Outputs are decoded from state alone, so reset forces them low
    // without waiting for a clock edge.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        clr_out   = 1'b0;
        busy      = (state_q != IDLE);
        overrun   = overrun_q;

        case (state_q)
            SEND: begin
                out_valid = 1'b1;
                out_data  = hold_q[idx_q];
                out_idx   = idx_q;
                out_last  = at_last;
            end
            CLEAR: begin
                clr_out = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_q    <= done_in;
            overrun_q <= overrun_d;
        end
    end

    // The capture register is loaded only on an accepted rise, so changes
    // on c_in during a drain never reach the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                hold_q[i] <= '0;
            end
        end else if (capture) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                hold_q[i] <= c_in[i];
            end
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// ---------------------------------------------------------------------------
// tb_result_drain
//   Directed bench for result_drain (LANES=8, DW=24). Inputs are driven and
//   outputs are sampled 1 ns after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_result_drain;

    localparam int unsigned LANES = 8;
    localparam int unsigned DW    = 24;

    logic          clk;
    logic          rst_n;
    logic          done_in;
    logic [DW-1:0] c_in [0:LANES-1];
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    out_idx;
    logic          out_last;
    logic          clr_out;
    logic          busy;
    logic          overrun;

    logic [DW-1:0] exp_w [0:LANES-1];
    int            checks;
    int            errors;

    result_drain #(.LANES(LANES), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .done_in   (done_in),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .clr_out   (clr_out),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".data"},  {8'd0, out_data},   32'd0);
        check({tag, ".idx"},   {29'd0, out_idx},   32'd0);
        check({tag, ".last"},  {31'd0, out_last},  32'd0);
        check({tag, ".clr"},   {31'd0, clr_out},   32'd0);
        check({tag, ".busy"},  {31'd0, busy},      32'd0);
    endtask

    // Streams words start..LANES-1 with out_ready high, then checks the
    // clear pulse and the return to IDLE.
    task automatic drain_from(input int start, input string tag);
        out_ready = 1'b1;
        for (int k = start; k < int'(LANES); k++) begin
            check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, ".data"},  {8'd0, out_data},   {8'd0, exp_w[k]});
            check({tag, ".idx"},   {29'd0, out_idx},   k);
            check({tag, ".last"},  {31'd0, out_last},  (k == 7) ? 32'd1 : 32'd0);
            check({tag, ".noclr"}, {31'd0, clr_out},   32'd0);
            tick();
        end
        check({tag, ".clr"},      {31'd0, clr_out},   32'd1);
        check({tag, ".clrvalid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".clrbusy"},  {31'd0, busy},      32'd1);
        tick();
        check({tag, ".clrone"},   {31'd0, clr_out},   32'd0);
        check({tag, ".idle"},     {31'd0, busy},      32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int e;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        done_in   = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < int'(LANES); k++) c_in[k] = '0;

        // Reset state
        tick();
        tick();
        check_idle_outputs("reset");
        check("reset.ovr", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_idle_outputs("noreq");

        // Basic drain, done_in held high across the whole drain
        for (int k = 0; k < int'(LANES); k++) begin
            c_in[k]  = DW'(k * 100 + 1);
            exp_w[k] = DW'(k * 100 + 1);
        end
        out_ready = 1'b1;
        done_in   = 1'b1;
        tick();
        drain_from(0, "basic");
        tick();
        tick();
        check("held.valid", {31'd0, out_valid}, 32'd0);
        check("held.busy",  {31'd0, busy},      32'd0);
        check("held.ovr",   {31'd0, overrun},   32'd0);
        done_in = 1'b0;
        tick();

        // Backpressure (ready 1,0,0,...) and capture isolation
        for (int k = 0; k < int'(LANES); k++) begin
            c_in[k]  = DW'(k * 16 + 5);
            exp_w[k] = DW'(k * 16 + 5);
        end
        out_ready = 1'b0;
        done_in   = 1'b1;
        tick();
        for (int k = 0; k < int'(LANES); k++) c_in[k] = 24'hFFFFFF;
        done_in = 1'b0;
        e   = 0;
        cyc = 0;
        while (e < int'(LANES) && cyc < 60) begin
            check("bp.valid", {31'd0, out_valid}, 32'd1);
            check("bp.data",  {8'd0, out_data},   {8'd0, exp_w[e]});
            check("bp.idx",   {29'd0, out_idx},   e);
            out_ready = (cyc % 3 == 0);
            tick();
            if (out_ready) e++;
            cyc++;
        end
        check("bp.count", e, LANES);
        check("bp.clr",   {31'd0, clr_out}, 32'd1);
        tick();
        check("bp.idle",  {31'd0, busy},    32'd0);

        // Overrun: second rise while word 3 is pending
        for (int k = 0; k < int'(LANES); k++) begin
            c_in[k]  = DW'(32'h10000 + k);
            exp_w[k] = DW'(32'h10000 + k);
        end
        out_ready = 1'b1;
        done_in   = 1'b1;
        tick();
        done_in = 1'b0;
        tick();
        tick();
        tick();
        check("ovr.idx3", {29'd0, out_idx}, 32'd3);
        out_ready = 1'b0;
        for (int k = 0; k < int'(LANES); k++) c_in[k] = 24'h0ABCDE;
        done_in = 1'b1;
        tick();
        check("ovr.set",   {31'd0, overrun},  32'd1);
        check("ovr.stall", {29'd0, out_idx},  32'd3);
        drain_from(3, "ovr");
        tick();
        tick();
        check("ovr.nodrain", {31'd0, out_valid}, 32'd0);
        check("ovr.sticky",  {31'd0, overrun},   32'd1);
        done_in = 1'b0;
        tick();

        // Mid-drain reset, then done_in high at reset release
        for (int k = 0; k < int'(LANES); k++) begin
            c_in[k]  = DW'(32'h200 + k * 3);
            exp_w[k] = DW'(32'h200 + k * 3);
        end
        out_ready = 1'b1;
        done_in   = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("mr.idx3", {29'd0, out_idx}, 32'd3);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mr.async");
        check("mr.ovr", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr.noclr", {31'd0, clr_out}, 32'd0);
        end
        for (int k = 0; k < int'(LANES); k++) begin
            c_in[k]  = DW'(32'hC00000 + k * 5);
            exp_w[k] = DW'(32'hC00000 + k * 5);
        end
        done_in = 1'b1;
        rst_n   = 1'b1;
        tick();
        drain_from(0, "rel");
        check("rel.ovr", {31'd0, overrun}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
